// File: rtl/dma_seq_ctrl.sv
// dma_seq_ctrl: DMA sub-buffer sequencer.
//
// Accepts one transfer command and programs the engine's six registers.
// It then counts completion interrupts buffer by buffer, acknowledging each
// one. When all buffers are done, or on abort, it disables the engine and
// pulses done with err.
//
// Optional build macro: DMA_SEQ_TIMEOUT_EN adds a per-sub-buffer watchdog.
// The watchdog forces ABORT after TIMEOUT_CYCLES cycles in WAIT.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake
//   cmd_src/dest      source / destination base addresses
//   cmd_size/nbuf     sub-buffer size (bytes) and sub-buffer count
//   abort             stop the running command
//   intr              engine completion interrupt (level)
//   reg_wr_data/en    engine register write port (one-hot enable)
//   busy, done, err   status; err is meaningful only while done=1
//   buf_cnt           sub-buffers completed for the current command
module dma_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_src,
  input  logic [31:0] cmd_dest,
  input  logic [31:0] cmd_size,
  input  logic [15:0] cmd_nbuf,
  input  logic        abort,
  input  logic        intr,
  output logic [31:0] reg_wr_data,
  output logic [5:0]  reg_wr_en,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] buf_cnt
);

  typedef enum logic [3:0] {
    IDLE, W_SRC, W_DEST, W_TAIL, W_SIZE, W_HEAD, W_CTRL,
    WAIT, ACK, HOLD, ABORT, DONE
  } state_t;

  // One-hot write-enable bits for the engine registers.
  localparam logic [5:0] EN_SRC  = 6'h01;
  localparam logic [5:0] EN_DEST = 6'h02;
  localparam logic [5:0] EN_TAIL = 6'h04;
  localparam logic [5:0] EN_HEAD = 6'h08;
  localparam logic [5:0] EN_SIZE = 6'h10;
  localparam logic [5:0] EN_CTRL = 6'h20;

  state_t      state, state_n;
  logic [31:0] src_q, dest_q, size_q;
  logic [15:0] nbuf_q;
  logic        err_q;
  logic        accept, reject, wdog_hit;
  logic [31:0] head_val;

  assign accept   = (state == IDLE) && cmd_valid;
  assign reject   = (cmd_nbuf == 16'd0) || (cmd_size == 32'd0);
  // The caller guarantees that the product fits in 32 bits.
  assign head_val = size_q * {16'd0, nbuf_q};

`ifdef DMA_SEQ_TIMEOUT_EN
  logic [31:0] wdog;
  // The counter is zero on the first WAIT cycle. It therefore reaches
  // TIMEOUT_CYCLES-1 on the last WAIT cycle, and ABORT follows
  // TIMEOUT_CYCLES cycles after WAIT was entered.
  always_ff @(posedge clk) begin
    if (rst || state != WAIT) wdog <= 32'd0;
    else                      wdog <= wdog + 32'd1;
  end
  assign wdog_hit = (wdog == 32'(TIMEOUT_CYCLES - 1));
`else
  assign wdog_hit = 1'b0;
`endif

  // Next state, with register writes decoded from the current state.
  always_comb begin
    state_n     = state;
    reg_wr_en   = 6'h00;
    reg_wr_data = 32'd0;
    case (state)
      IDLE:   if (cmd_valid) state_n = reject ? DONE : W_SRC;
      W_SRC:  begin reg_wr_en = EN_SRC;  reg_wr_data = src_q;    state_n = W_DEST; end
      W_DEST: begin reg_wr_en = EN_DEST; reg_wr_data = dest_q;   state_n = W_TAIL; end
      W_TAIL: begin reg_wr_en = EN_TAIL; reg_wr_data = 32'd0;    state_n = W_SIZE; end
      W_SIZE: begin reg_wr_en = EN_SIZE; reg_wr_data = size_q;   state_n = W_HEAD; end
      W_HEAD: begin reg_wr_en = EN_HEAD; reg_wr_data = head_val; state_n = W_CTRL; end
      W_CTRL: begin reg_wr_en = EN_CTRL; reg_wr_data = 32'h1;    state_n = WAIT;   end
      WAIT: begin
        if (intr)          state_n = ACK;
        else if (wdog_hit) state_n = ABORT;
      end
      ACK: begin
        // buf_cnt has already been incremented on the way into ACK.
        reg_wr_en = EN_CTRL;
        if (buf_cnt == nbuf_q) begin
          reg_wr_data = 32'h0;
          state_n     = DONE;
        end else begin
          reg_wr_data = 32'h1;
          state_n     = HOLD;
        end
      end
      // The intr level may still be stale here, so it is not sampled.
      HOLD:   state_n = WAIT;
      ABORT:  begin reg_wr_en = EN_CTRL; reg_wr_data = 32'h0; state_n = DONE; end
      DONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // abort takes priority over every other transition, intr included.
    if (abort && (state inside {W_SRC, W_DEST, W_TAIL, W_SIZE, W_HEAD,
                                W_CTRL, WAIT, ACK, HOLD}))
      state_n = ABORT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q   <= 32'd0;
      dest_q  <= 32'd0;
      size_q  <= 32'd0;
      nbuf_q  <= 16'd0;
      buf_cnt <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        src_q   <= cmd_src;
        dest_q  <= cmd_dest;
        size_q  <= cmd_size;
        nbuf_q  <= cmd_nbuf;
        buf_cnt <= 16'd0;
        err_q   <= reject;
      end
      // A buffer counts only when the WAIT->ACK move wins, so intr that
      // arrives together with abort is not counted.
      if (state == WAIT && state_n == ACK) buf_cnt <= buf_cnt + 16'd1;
      if (state_n == ABORT && state != ABORT) err_q <= 1'b1;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign err       = (state == DONE) && err_q;

endmodule
